vga_bounce_gen: RTL and testbench

- Pixel-data source for the VGA controller: animated solid box bouncing off the edges of the 640x480 active area.
- Input: the pixel address (h_addr, v_addr) from the controller. Output: 24-bit RGB data_display back to the controller.
- Runs in the 25 MHz pixel clock domain, in the data-generator slot of the display top.

---
 rtl/vga_bounce_gen.sv | 142 ++++++++++++++
 tb/tb_vga_bounce_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_bounce_gen.sv
// Bouncing-box pixel source: registered RGB one clock after the pixel address,
// frame tick one clock after the last active pixel; no backpressure, one pixel per clock.
module vga_bounce_gen #(
    parameter int          H_ACT    = 640,
    parameter int          V_ACT    = 480,
    parameter int          BOX_W    = 64,
    parameter int          BOX_H    = 48,
    parameter int          STEP_X   = 2,
    parameter int          STEP_Y   = 2,
    parameter logic [23:0] BG_COLOR = 24'h000040
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] h_addr,
    input  logic [10:0] v_addr,
    input  logic        move_en,
    output logic [23:0] data_display,
    output logic        frame_tick
);

    typedef enum logic [1:0] {DR, DL, UR, UL} dir_e;

    localparam logic [11:0] X_MAX  = 12'(H_ACT - BOX_W);
    localparam logic [11:0] Y_MAX  = 12'(V_ACT - BOX_H);
    localparam logic [11:0] STEP_XW = 12'(STEP_X);
    localparam logic [11:0] STEP_YW = 12'(STEP_Y);

    dir_e        state, state_nx;
    logic [10:0] box_x, box_y, box_x_nx, box_y_nx;
    logic [2:0]  color_idx, color_nx;
    logic        last_px, last_now;
    logic [23:0] pix_nx, pal;
    logic [11:0] sum_x, sum_y, x_end, y_end;
    logic        mv_right, mv_down, right_nx, down_nx, bounce_x, bounce_y;
    logic        in_act, in_box;

    always_comb begin
        case (color_idx)
            3'd0:    pal = 24'hFF0000;
            3'd1:    pal = 24'h00FF00;
            3'd2:    pal = 24'h0000FF;
            3'd3:    pal = 24'hFFFF00;
            3'd4:    pal = 24'h00FFFF;
            3'd5:    pal = 24'hFF00FF;
            3'd6:    pal = 24'hFFFFFF;
            default: pal = 24'hFF8000;
        endcase
    end

    always_comb begin
        x_end  = {1'b0, box_x} + 12'(BOX_W);
        y_end  = {1'b0, box_y} + 12'(BOX_H);
        in_act = (h_addr < 11'(H_ACT)) && (v_addr < 11'(V_ACT));
        in_box = (h_addr >= box_x) && ({1'b0, h_addr} < x_end) &&
                 (v_addr >= box_y) && ({1'b0, v_addr} < y_end);
        if (!in_act)
            pix_nx = 24'h000000;
        else if (in_box)
            pix_nx = pal;
        else
            pix_nx = BG_COLOR;
        last_now = (h_addr == 11'(H_ACT - 1)) && (v_addr == 11'(V_ACT - 1));
    end

    // Direction FSM and position step; evaluated only on an enabled frame tick.
    always_comb begin
        box_x_nx = box_x;
        box_y_nx = box_y;
        color_nx = color_idx;
        state_nx = state;
        bounce_x = 1'b0;
        bounce_y = 1'b0;
        mv_right = (state == DR) || (state == UR);
        mv_down  = (state == DR) || (state == DL);
        right_nx = mv_right;
        down_nx  = mv_down;
        sum_x    = {1'b0, box_x} + STEP_XW;
        sum_y    = {1'b0, box_y} + STEP_YW;
        if (frame_tick && move_en) begin
            if (mv_right) begin
                if (sum_x >= X_MAX) begin
                    box_x_nx = X_MAX[10:0];
                    right_nx = 1'b0;
                    bounce_x = 1'b1;
                end else begin
                    box_x_nx = sum_x[10:0];
                end
            end else if ({1'b0, box_x} <= STEP_XW) begin
                box_x_nx = 11'd0;
                right_nx = 1'b1;
                bounce_x = 1'b1;
            end else begin
                box_x_nx = box_x - STEP_XW[10:0];
            end
            if (mv_down) begin
                if (sum_y >= Y_MAX) begin
                    box_y_nx = Y_MAX[10:0];
                    down_nx  = 1'b0;
                    bounce_y = 1'b1;
                end else begin
                    box_y_nx = sum_y[10:0];
                end
            end else if ({1'b0, box_y} <= STEP_YW) begin
                box_y_nx = 11'd0;
                down_nx  = 1'b1;
                bounce_y = 1'b1;
            end else begin
                box_y_nx = box_y - STEP_YW[10:0];
            end
            // A corner hit is one colour step, not two.
            if (bounce_x || bounce_y)
                color_nx = color_idx + 3'd1;
            case ({right_nx, down_nx})
                2'b11:   state_nx = DR;
                2'b01:   state_nx = DL;
                2'b10:   state_nx = UR;
                default: state_nx = UL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_display <= 24'h000000;
            frame_tick   <= 1'b0;
            last_px      <= 1'b0;
            box_x        <= 11'd0;
            box_y        <= 11'd0;
            color_idx    <= 3'd0;
            state        <= DR;
        end else begin
            data_display <= pix_nx;
            last_px      <= last_now;
            frame_tick   <= last_now && !last_px;
            box_x        <= box_x_nx;
            box_y        <= box_y_nx;
            color_idx    <= color_nx;
            state        <= state_nx;
        end
    end

endmodule

// File: tb/tb_vga_bounce_gen.sv
// Bench for vga_bounce_gen: default instance plus a tall-box instance for the corner case.
module tb_vga_bounce_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] h_addr = 11'd0;
    logic [10:0] v_addr = 11'd0;
    logic        move_en = 1'b1;
    logic [23:0] data_a, data_b;
    logic        tick_a, tick_b;

    always #20 clk = ~clk;

    vga_bounce_gen dut_a (
        .clk(clk), .rst_n(rst_n), .h_addr(h_addr), .v_addr(v_addr),
        .move_en(move_en), .data_display(data_a), .frame_tick(tick_a)
    );

    vga_bounce_gen #(.BOX_H(192), .STEP_Y(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .h_addr(h_addr), .v_addr(v_addr),
        .move_en(move_en), .data_display(data_b), .frame_tick(tick_b)
    );

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic        tick;
        string       tag;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_err = 0;
    int n_ticks = 0;

    // Reference model state, one slot per instance.
    int bw[2] = '{64, 64};
    int bh[2] = '{48, 192};
    int sx[2] = '{2, 2};
    int sy[2] = '{2, 1};
    int bx[2], by[2], col[2];
    bit go_right[2], go_down[2];
    bit m_prev_last, m_tick;

    bit          fa_en, fb_en;
    logic [23:0] fa, fb;

    function automatic logic [23:0] pal(input int c);
        logic [23:0] p [8];
        p = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
              24'h00FFFF, 24'hFF00FF, 24'hFFFFFF, 24'hFF8000};
        return p[c];
    endfunction

    function automatic logic [23:0] model_pix(input int i, input int h, input int v);
        if (h >= 640 || v >= 480) return 24'h000000;
        if (h >= bx[i] && h < bx[i] + bw[i] && v >= by[i] && v < by[i] + bh[i])
            return pal(col[i]);
        return 24'h000040;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            bx[i] = 0; by[i] = 0; col[i] = 0;
            go_right[i] = 1'b1; go_down[i] = 1'b1;
        end
        m_prev_last = 1'b0;
        m_tick = 1'b0;
    endtask

    task automatic model_move(input int i);
        bit bounced;
        bounced = 1'b0;
        if (go_right[i]) begin
            if (bx[i] + sx[i] >= 640 - bw[i]) begin
                bx[i] = 640 - bw[i]; go_right[i] = 1'b0; bounced = 1'b1;
            end else bx[i] += sx[i];
        end else begin
            if (bx[i] <= sx[i]) begin
                bx[i] = 0; go_right[i] = 1'b1; bounced = 1'b1;
            end else bx[i] -= sx[i];
        end
        if (go_down[i]) begin
            if (by[i] + sy[i] >= 480 - bh[i]) begin
                by[i] = 480 - bh[i]; go_down[i] = 1'b0; bounced = 1'b1;
            end else by[i] += sy[i];
        end else begin
            if (by[i] <= sy[i]) begin
                by[i] = 0; go_down[i] = 1'b1; bounced = 1'b1;
            end else by[i] -= sy[i];
        end
        if (bounced) col[i] = (col[i] + 1) % 8;
    endtask

    task automatic want_a(input logic [23:0] a);
        fa_en = 1'b1; fa = a;
    endtask

    task automatic want_b(input logic [23:0] b);
        fb_en = 1'b1; fb = b;
    endtask

    // One pixel per clock: drive address, queue the expected response, advance model.
    task automatic step(input int h, input int v, input string tag);
        exp_t e;
        bit   last;
        @(negedge clk);
        h_addr = 11'(h);
        v_addr = 11'(v);
        last   = (h == 639 && v == 479);
        e.a    = fa_en ? fa : model_pix(0, h, v);
        e.b    = fb_en ? fb : model_pix(1, h, v);
        e.tick = last && !m_prev_last;
        e.tag  = tag;
        fa_en  = 1'b0;
        fb_en  = 1'b0;
        q.push_back(e);
        if (m_tick && move_en) begin
            model_move(0);
            model_move(1);
        end
        m_prev_last = last;
        m_tick      = e.tick;
    endtask

    task automatic rand_step();
        int h, v;
        if ($urandom_range(0, 1) == 1) begin
            h = bx[0] + int'($urandom_range(0, 67)) - 2;
            v = by[0] + int'($urandom_range(0, 51)) - 2;
            if (h < 0) h = 0;
            if (v < 0) v = 0;
        end else begin
            h = int'($urandom_range(0, 700));
            v = int'($urandom_range(0, 520));
        end
        if (h == 639 && v == 479) h = 0;
        step(h, v, "rand_px");
    endtask

    task automatic do_tick(input int hold);
        for (int k = 0; k < hold; k++) step(639, 479, "tick_hold");
        step(0, 0, "tick_follow");
        for (int k = 0; k < int'($urandom_range(1, 4)); k++) rand_step();
    endtask

    task automatic check_now(input string tag, input logic [23:0] act, input logic [23:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, req);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if (tick_a) n_ticks++;
            if (data_a !== e.a || data_b !== e.b || tick_a !== e.tick || tick_b !== e.tick) begin
                n_err++;
                $display("FAIL %s h=%0d v=%0d: got a=%h b=%h tick=%b/%b expected a=%h b=%h tick=%b",
                         e.tag, h_addr, v_addr, data_a, data_b, tick_a, tick_b, e.a, e.b, e.tick);
            end
        end
    end

    initial begin
        int ticks_before;
        fa_en = 1'b0; fb_en = 1'b0; fa = '0; fb = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_now("reset_data_a", data_a, 24'h000000);
        check_now("reset_data_b", data_b, 24'h000000);
        check_now("reset_tick", {23'd0, tick_a}, 24'd0);
        rst_n = 1'b1;

        want_a(24'hFF0000); want_b(24'hFF0000); step(0, 0, "origin_in_box");
        want_a(24'h000040); step(64, 0, "right_of_box");
        want_a(24'h000000); want_b(24'h000000); step(640, 0, "blanking");

        do_tick(5);
        step(0, 0, "idle");
        want_a(24'h000040); step(1, 1, "after_tick1_bg");
        want_a(24'hFF0000); step(2, 2, "after_tick1_box");

        for (int t = 2; t <= 216; t++) do_tick(int'($urandom_range(1, 5)));
        step(0, 0, "idle");
        want_a(24'h00FF00); step(432, 432, "t216_box_corner");
        want_a(24'h000040); step(431, 432, "t216_left_edge");

        for (int t = 217; t <= 288; t++) do_tick(int'($urandom_range(1, 5)));
        step(0, 0, "idle");
        want_a(24'h0000FF); want_b(24'h00FF00); step(576, 288, "t288_box_corner");
        want_a(24'h000040); want_b(24'h00FF00); step(600, 400, "t288_tall_box");
        want_a(24'h000040); want_b(24'h000040); step(576, 287, "t288_above_box");

        for (int t = 0; t < 40; t++) begin
            move_en = 1'($urandom_range(0, 1));
            do_tick(int'($urandom_range(1, 5)));
        end

        move_en = 1'b1;
        step(0, 0, "idle");
        repeat (2) @(posedge clk);
        ticks_before = n_ticks;
        move_en = 1'b0;
        for (int t = 0; t < 10; t++) do_tick(int'($urandom_range(1, 5)));
        for (int k = 0; k < 6; k++) rand_step();
        repeat (2) @(posedge clk);
        #2;
        check_now("frozen_tick_count", 24'(n_ticks - ticks_before), 24'd10);

        move_en = 1'b1;
        step(5, 5, "pre_reset");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_now("midline_reset_a", data_a, 24'h000000);
        check_now("midline_reset_b", data_b, 24'h000000);
        check_now("midline_reset_tick", {23'd0, tick_a}, 24'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        want_a(24'hFF0000); want_b(24'hFF0000); step(0, 0, "post_reset_origin");
        want_a(24'h000040); step(64, 0, "post_reset_right");
        do_tick(2);
        step(0, 0, "idle");
        want_a(24'h000040); step(1, 1, "post_reset_tick_bg");
        want_a(24'hFF0000); step(2, 2, "post_reset_tick_box");

        repeat (4) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expected responses never checked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
